// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM. Port A has priority, and port B is forced after STARVE_MAX denied cycles.
// Grants are combinational in the request cycle; rvalid and rdata follow one cycle later.
module mem_arbiter #(
   parameter int AW         = 16,
   parameter int DW         = 16,
   parameter int STARVE_MAX = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_gnt,
   output logic          a_rvalid,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_gnt,
   output logic          b_rvalid,
   output logic [DW-1:0] b_rdata,
   output logic [AW-1:0] ram_address,
   output logic [DW-1:0] ram_data,
   output logic          ram_rden,
   output logic          ram_wren,
   input  logic [DW-1:0] ram_q
);

   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   typedef enum logic {PRI_A, FORCE_B} arbState;

   arbState       state;
   logic [CW-1:0] starveCnt;
   logic [CW-1:0] starveNext;
   logic          forceB;
   logic          aGrant;
   logic          bGrant;

   always_comb begin
      forceB = (state == FORCE_B) && b_req;
      // Grants are gated by reset so that the RAM sees no access while reset is held.
      aGrant = !reset && a_req && !forceB;
      bGrant = !reset && b_req && (forceB || !a_req);
      if (b_req && !bGrant)
         starveNext = (starveCnt == STARVE_LIM) ? starveCnt : starveCnt + 1'b1;
      else
         starveNext = '0;
   end

   assign a_gnt       = aGrant;
   assign b_gnt       = bGrant;
   assign ram_address = bGrant ? b_addr  : a_addr;
   assign ram_data    = bGrant ? b_wdata : a_wdata;
   assign ram_wren    = (aGrant & a_we)  | (bGrant & b_we);
   assign ram_rden    = (aGrant & ~a_we) | (bGrant & ~b_we);
   assign a_rdata     = ram_q;
   assign b_rdata     = ram_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= PRI_A;
         starveCnt <= '0;
         a_rvalid  <= 1'b0;
         b_rvalid  <= 1'b0;
      end else begin
         starveCnt <= starveNext;
         a_rvalid  <= aGrant & ~a_we;
         b_rvalid  <= bGrant & ~b_we;
         case (state)
            PRI_A:   if (starveNext == STARVE_LIM) state <= FORCE_B;
            FORCE_B: if (bGrant || !b_req) state <= PRI_A;
            default: state <= PRI_A;
         endcase
      end
   end

endmodule
